// File: rtl/as_bus_master_if.sv
// Byte-stream (i2c_slave side) and Wishbone-style bus signals of as_bus_master.
// The master modport is the command sequencer; the slave modport is its environment.
interface as_bus_master_if;
  logic [7:0]  as_data_i;
  logic        as_dstrb_i;
  logic [7:0]  as_data_o;
  logic        as_dstrb_o;
  logic        as_busy_i;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [15:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    input  as_data_i, as_dstrb_i, as_busy_i, wb_dat_i, wb_ack_i,
    output as_data_o, as_dstrb_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
  );

  modport slave (
    output as_data_i, as_dstrb_i, as_busy_i, wb_dat_i, wb_ack_i,
    input  as_data_o, as_dstrb_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o
  );
endinterface

// File: rtl/as_bus_master.sv
// Command sequencer: turns I2C byte commands into single 16-bit bus reads/writes
// and streams a status (plus read data) reply back through the I2C slave.
module as_bus_master #(
  parameter int BUS_TIMEOUT  = 1000,
  parameter int BYTE_TIMEOUT = 400000
) (
  input  logic            clk,
  input  logic            reset,
  as_bus_master_if.master bus,
  output logic            drop_o,
  output logic            timeout_o
);
  localparam int BUS_W  = $clog2(BUS_TIMEOUT + 1);
  localparam int BYTE_W = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [BUS_W-1:0]  BUS_LAST  = BUS_W'(BUS_TIMEOUT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTE_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADH, ADL, DH, DL, BUS, RESP} state_t;

  state_t            state_reg, state_next;
  logic              we_reg, we_next;
  logic [15:0]       adr_reg, adr_next;
  logic [15:0]       wdat_reg, wdat_next;
  logic [15:0]       rdat_reg, rdat_next;
  logic [7:0]        status_reg, status_next;
  logic              cyc_reg, cyc_next;
  logic [BYTE_W-1:0] byte_cnt_reg, byte_cnt_next;
  logic [BUS_W-1:0]  bus_cnt_reg, bus_cnt_next;
  logic [1:0]        idx_reg, idx_next;
  logic              busy_seen_reg, busy_seen_next;
  logic [7:0]        tx_data_reg, tx_data_next;
  logic              tx_stb_reg, tx_stb_next;
  logic              drop_reg, drop_next;
  logic              timeout_reg, timeout_next;

  logic              go_bus, go_resp;
  logic [1:0]        reply_len;
  logic [7:0]        reply_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      adr_reg       <= '0;
      wdat_reg      <= '0;
      rdat_reg      <= '0;
      status_reg    <= '0;
      cyc_reg       <= 1'b0;
      byte_cnt_reg  <= '0;
      bus_cnt_reg   <= '0;
      idx_reg       <= '0;
      busy_seen_reg <= 1'b0;
      tx_data_reg   <= '0;
      tx_stb_reg    <= 1'b0;
      drop_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      we_reg        <= we_next;
      adr_reg       <= adr_next;
      wdat_reg      <= wdat_next;
      rdat_reg      <= rdat_next;
      status_reg    <= status_next;
      cyc_reg       <= cyc_next;
      byte_cnt_reg  <= byte_cnt_next;
      bus_cnt_reg   <= bus_cnt_next;
      idx_reg       <= idx_next;
      busy_seen_reg <= busy_seen_next;
      tx_data_reg   <= tx_data_next;
      tx_stb_reg    <= tx_stb_next;
      drop_reg      <= drop_next;
      timeout_reg   <= timeout_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    we_next        = we_reg;
    adr_next       = adr_reg;
    wdat_next      = wdat_reg;
    rdat_next      = rdat_reg;
    status_next    = status_reg;
    cyc_next       = cyc_reg;
    byte_cnt_next  = byte_cnt_reg;
    bus_cnt_next   = bus_cnt_reg;
    idx_next       = idx_reg;
    busy_seen_next = busy_seen_reg;
    tx_data_next   = tx_data_reg;
    tx_stb_next    = 1'b0;
    drop_next      = 1'b0;
    timeout_next   = 1'b0;
    go_bus         = 1'b0;
    go_resp        = 1'b0;
    reply_len      = we_reg ? 2'd1 : 2'd3;

    case (idx_reg)
      2'd0:    reply_byte = status_reg;
      2'd1:    reply_byte = rdat_reg[15:8];
      default: reply_byte = rdat_reg[7:0];
    endcase

    case (state_reg)
      IDLE: begin
        if (bus.as_dstrb_i) begin
          if (bus.as_data_i == 8'h01 || bus.as_data_i == 8'h02) begin
            we_next       = (bus.as_data_i == 8'h01);
            state_next    = CMD;
            byte_cnt_next = '0;
          end else begin
            drop_next = 1'b1;
          end
        end
      end
      CMD, ADH, ADL, DH: begin
        // A read is complete once ADL is in; a write still waits for DH/DL.
        if (state_reg == ADL && !we_reg) begin
          go_bus    = 1'b1;
          drop_next = bus.as_dstrb_i;
        end else if (byte_cnt_reg == BYTE_LAST) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
          drop_next    = bus.as_dstrb_i;
        end else if (bus.as_dstrb_i) begin
          byte_cnt_next = '0;
          case (state_reg)
            CMD: begin
              adr_next[15:8] = bus.as_data_i;
              state_next     = ADH;
            end
            ADH: begin
              adr_next[7:0] = bus.as_data_i;
              state_next    = ADL;
            end
            ADL: begin
              wdat_next[15:8] = bus.as_data_i;
              state_next      = DH;
            end
            default: begin
              wdat_next[7:0] = bus.as_data_i;
              state_next     = DL;
            end
          endcase
        end else begin
          byte_cnt_next = byte_cnt_reg + BYTE_W'(1);
        end
      end
      DL: begin
        go_bus    = 1'b1;
        drop_next = bus.as_dstrb_i;
      end
      BUS: begin
        drop_next = bus.as_dstrb_i;
        if (bus.wb_ack_i) begin
          status_next = 8'h00;
          if (!we_reg) rdat_next = bus.wb_dat_i;
          go_resp = 1'b1;
        end else if (bus_cnt_reg == BUS_LAST) begin
          status_next  = 8'hEE;
          rdat_next    = 16'hEEEE;
          timeout_next = 1'b1;
          go_resp      = 1'b1;
        end else begin
          bus_cnt_next = bus_cnt_reg + BUS_W'(1);
        end
      end
      RESP: begin
        drop_next = bus.as_dstrb_i;
        // Each byte needs the slave to have shown busy since the previous one.
        if (idx_reg < reply_len) begin
          if (!bus.as_busy_i && busy_seen_reg) begin
            tx_stb_next    = 1'b1;
            tx_data_next   = reply_byte;
            idx_next       = idx_reg + 2'd1;
            busy_seen_next = 1'b0;
          end else if (bus.as_busy_i) begin
            busy_seen_next = 1'b1;
          end
        end else if (busy_seen_reg) begin
          state_next = IDLE;
        end else if (bus.as_busy_i) begin
          busy_seen_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (go_bus) begin
      state_next   = BUS;
      cyc_next     = 1'b1;
      bus_cnt_next = '0;
    end
    if (go_resp) begin
      state_next     = RESP;
      cyc_next       = 1'b0;
      idx_next       = '0;
      busy_seen_next = 1'b1;
    end
  end

  assign bus.wb_cyc_o   = cyc_reg;
  assign bus.wb_stb_o   = cyc_reg;
  assign bus.wb_we_o    = we_reg;
  assign bus.wb_adr_o   = adr_reg;
  assign bus.wb_dat_o   = wdat_reg;
  assign bus.as_data_o  = tx_data_reg;
  assign bus.as_dstrb_o = tx_stb_reg;
  assign drop_o         = drop_reg;
  assign timeout_o      = timeout_reg;
endmodule

// File: tb/tb_as_bus_master.sv
// Randomized scoreboard bench for as_bus_master: a register-file reference model
// predicts bus operations and reply bytes; a monitor checks what the DUT presents.
module tb_as_bus_master;
  localparam int BUS_TO  = 20;
  localparam int BYTE_TO = 60;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic drop_o, timeout_o;

  as_bus_master_if bus_if();

  as_bus_master #(.BUS_TIMEOUT(BUS_TO), .BYTE_TIMEOUT(BYTE_TO)) dut (
    .clk(clk), .reset(reset), .bus(bus_if), .drop_o(drop_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat;
    logic        acked;
    logic        chk_len;
  } bus_exp_t;

  bus_exp_t    exp_bus[$];
  logic [7:0]  exp_reply[$];
  logic [15:0] model_mem[logic [15:0]];
  logic [15:0] slave_mem[logic [15:0]];
  logic [15:0] addr_pool[6] = '{16'h1234, 16'h0010, 16'h0020, 16'hFFFF, 16'h8001, 16'h0000};

  int checks = 0, failures = 0;
  int cycle_no = 0, last_strobe_cycle = 0;
  int drops_seen = 0, timeouts_seen = 0, exp_drops = 0, exp_timeouts = 0;
  int replies_seen = 0;
  bit noack = 1'b0;
  int ack_lat = -1;

  always @(posedge clk) cycle_no++;

  // Unwritten registers read back a fixed function of their address.
  function automatic logic [15:0] power_on_value(input logic [15:0] adr);
    return adr ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] adr);
    if (model_mem.exists(adr)) return model_mem[adr];
    return power_on_value(adr);
  endfunction

  // Bus slave: a register file that acks after a chosen or random delay.
  initial begin : bus_slave
    bit in_cycle = 1'b0;
    int wait_cnt = 0, cur_delay = 0;
    bus_if.wb_ack_i = 1'b0;
    bus_if.wb_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      bus_if.wb_ack_i = 1'b0;
      bus_if.wb_dat_i = 16'($urandom);
      if (bus_if.wb_cyc_o && bus_if.wb_stb_o && !noack) begin
        if (!in_cycle) begin
          in_cycle  = 1'b1;
          wait_cnt  = 0;
          cur_delay = (ack_lat >= 0) ? ack_lat : int'($urandom_range(0, 4));
        end
        if (wait_cnt >= cur_delay) begin
          bus_if.wb_ack_i = 1'b1;
          if (bus_if.wb_we_o) slave_mem[bus_if.wb_adr_o] = bus_if.wb_dat_o;
          else if (slave_mem.exists(bus_if.wb_adr_o)) bus_if.wb_dat_i = slave_mem[bus_if.wb_adr_o];
          else bus_if.wb_dat_i = power_on_value(bus_if.wb_adr_o);
          in_cycle = 1'b0;
        end else begin
          wait_cnt++;
        end
      end else if (!bus_if.wb_cyc_o) begin
        in_cycle = 1'b0;
      end
    end
  end

  // I2C slave transmit side: busy rises some cycles after each byte, then falls.
  initial begin : i2c_slave
    bus_if.as_busy_i = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_if.as_dstrb_o) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 bus_if.as_busy_i = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 bus_if.as_busy_i = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a bus cycle or emits a byte.
  logic        cyc_prev = 1'b0, saw_ack, stable, busy_since = 1'b1;
  logic        cur_we;
  logic [15:0] cur_adr, cur_dat;
  int          cyc_len;
  bus_exp_t    mon_e;
  logic [7:0]  mon_b;

  always @(negedge clk) begin
    if (bus_if.wb_cyc_o) begin
      if (!cyc_prev) begin
        cur_we = bus_if.wb_we_o; cur_adr = bus_if.wb_adr_o; cur_dat = bus_if.wb_dat_o;
        cyc_len = 0; saw_ack = 1'b0; stable = 1'b1;
        checks++;
        if (cycle_no - last_strobe_cycle != 2) begin
          failures++;
          $display("FAIL stb_latency: got %0d cycles, expected 2", cycle_no - last_strobe_cycle);
        end
      end
      cyc_len++;
      if (!bus_if.wb_stb_o || bus_if.wb_we_o !== cur_we || bus_if.wb_adr_o !== cur_adr ||
          bus_if.wb_dat_o !== cur_dat) stable = 1'b0;
      if (bus_if.wb_ack_i) saw_ack = 1'b1;
    end else if (cyc_prev) begin
      checks++;
      if (exp_bus.size() == 0) begin
        failures++;
        $display("FAIL bus_op: unexpected cycle we=%0b adr=%h dat=%h, expected none", cur_we, cur_adr, cur_dat);
      end else begin
        mon_e = exp_bus.pop_front();
        if (cur_we !== mon_e.we || cur_adr !== mon_e.adr || (mon_e.we && cur_dat !== mon_e.dat) ||
            saw_ack !== mon_e.acked || !stable || (mon_e.chk_len && cyc_len != BUS_TO)) begin
          failures++;
          $display("FAIL bus_op: got we=%0b adr=%h dat=%h ack=%0b stable=%0b len=%0d, expected we=%0b adr=%h dat=%h ack=%0b len=%0d",
                   cur_we, cur_adr, cur_dat, saw_ack, stable, cyc_len, mon_e.we, mon_e.adr, mon_e.dat,
                   mon_e.acked, mon_e.chk_len ? BUS_TO : cyc_len);
        end
      end
    end
    cyc_prev = bus_if.wb_cyc_o;

    if (bus_if.as_dstrb_o) begin
      replies_seen++;
      checks++;
      if (exp_reply.size() == 0) begin
        failures++;
        $display("FAIL reply_byte: unexpected byte %h, expected none", bus_if.as_data_o);
      end else begin
        mon_b = exp_reply.pop_front();
        if (bus_if.as_data_o !== mon_b) begin
          failures++;
          $display("FAIL reply_byte: got %h, expected %h", bus_if.as_data_o, mon_b);
        end
      end
      checks++;
      if (!busy_since || bus_if.as_busy_i) begin
        failures++;
        $display("FAIL reply_handshake: busy_seen_since_last=%0b busy_now=%0b, expected 1 and 0", busy_since, bus_if.as_busy_i);
      end
      busy_since = 1'b0;
    end
    if (bus_if.as_busy_i) busy_since = 1'b1;
    if (drop_o) drops_seen++;
    if (timeout_o) timeouts_seen++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    #1;
    bus_if.as_data_i  = b;
    bus_if.as_dstrb_i = 1'b1;
    last_strobe_cycle = cycle_no;
    @(posedge clk); #1;
    bus_if.as_dstrb_i = 1'b0;
  endtask

  task automatic issue_write(input logic [15:0] adr, input logic [15:0] dat, input bit to);
    bus_exp_t e;
    e.we = 1'b1; e.adr = adr; e.dat = dat; e.acked = !to; e.chk_len = to;
    exp_bus.push_back(e);
    exp_reply.push_back(to ? 8'hEE : 8'h00);
    if (to) exp_timeouts++; else model_mem[adr] = dat;
    send_byte(8'h01); send_byte(adr[15:8]); send_byte(adr[7:0]);
    send_byte(dat[15:8]); send_byte(dat[7:0]);
  endtask

  task automatic issue_read(input logic [15:0] adr, input bit to);
    bus_exp_t e;
    logic [15:0] d;
    d = to ? 16'hEEEE : model_read(adr);
    e.we = 1'b0; e.adr = adr; e.dat = '0; e.acked = !to; e.chk_len = to;
    exp_bus.push_back(e);
    exp_reply.push_back(to ? 8'hEE : 8'h00);
    exp_reply.push_back(d[15:8]);
    exp_reply.push_back(d[7:0]);
    if (to) exp_timeouts++;
    send_byte(8'h02); send_byte(adr[15:8]); send_byte(adr[7:0]);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_bus.size() != 0 || exp_reply.size() != 0) && n < 800) begin
      @(negedge clk); n++;
    end
    checks++;
    if (exp_bus.size() != 0 || exp_reply.size() != 0) begin
      failures++;
      $display("FAIL %s_complete: %0d bus ops and %0d reply bytes outstanding, expected 0",
               name, exp_bus.size(), exp_reply.size());
      exp_bus.delete(); exp_reply.delete();
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic check_counts(input string name);
    checks++;
    if (drops_seen != exp_drops || timeouts_seen != exp_timeouts) begin
      failures++;
      $display("FAIL %s_pulses: drops=%0d timeouts=%0d, expected drops=%0d timeouts=%0d",
               name, drops_seen, timeouts_seen, exp_drops, exp_timeouts);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.wb_we_o, bus_if.wb_adr_o, bus_if.wb_dat_o,
         bus_if.as_data_o, bus_if.as_dstrb_o, drop_o, timeout_o} !== '0) begin
      failures++;
      $display("FAIL %s: cyc=%b stb=%b we=%b adr=%h dat=%h data_o=%h dstrb_o=%b drop=%b timeout=%b, expected all 0",
               name, bus_if.wb_cyc_o, bus_if.wb_stb_o, bus_if.wb_we_o, bus_if.wb_adr_o, bus_if.wb_dat_o,
               bus_if.as_data_o, bus_if.as_dstrb_o, drop_o, timeout_o);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    logic [7:0] b;
    bus_exp_t e;
    bus_if.as_data_i  = '0;
    bus_if.as_dstrb_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset_state");
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);

    ack_lat = 3;
    issue_write(16'h1234, 16'hABCD, 1'b0);
    wait_done("write");
    issue_write(16'h0010, 16'hBEEF, 1'b0);
    wait_done("write2");
    issue_read(16'h0010, 1'b0);
    wait_done("read");

    noack = 1'b1;
    issue_read(16'h0020, 1'b1);
    repeat (5) @(posedge clk);
    send_byte(8'h99);
    exp_drops++;
    wait_done("bus_timeout");
    noack = 1'b0;
    check_counts("bus_timeout");

    send_byte(8'h7F);
    exp_drops++;
    send_byte(8'h01);
    send_byte(8'h00);
    n = 0;
    while (!timeout_o && n < 4 * BYTE_TO) begin
      @(negedge clk); n++;
    end
    exp_timeouts++;
    checks++;
    if (n < BYTE_TO - 2 || n > BYTE_TO + 2) begin
      failures++;
      $display("FAIL byte_timeout_delay: got %0d cycles, expected %0d +/- 2", n, BYTE_TO);
    end
    repeat (3) @(negedge clk);
    issue_read(16'h1234, 1'b0);
    wait_done("read_after_timeout");
    check_counts("byte_timeout");

    issue_read(16'h0010, 1'b0);
    n = 0;
    while (replies_seen == 0 || exp_reply.size() == 3) begin
      @(negedge clk); n++;
      if (n > 300) break;
    end
    send_byte(8'h55);
    exp_drops++;
    wait_done("overrun");
    check_counts("overrun");

    noack = 1'b1;
    e.we = 1'b0; e.adr = 16'h0030; e.dat = '0; e.acked = 1'b0; e.chk_len = 1'b0;
    exp_bus.push_back(e);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h30);
    n = 0;
    while (!bus_if.wb_cyc_o && n < 20) begin
      @(negedge clk); n++;
    end
    checks++;
    if (!bus_if.wb_cyc_o) begin
      failures++;
      $display("FAIL reset_bus_start: cyc=0 after %0d cycles, expected 1", n);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset_in_bus");
    @(posedge clk); #1 reset = 1'b0;
    noack = 1'b0;
    issue_write(16'h0030, 16'h5A5A, 1'b0);
    wait_done("write_after_reset");
    issue_read(16'h0030, 1'b0);
    wait_done("read_after_reset");

    ack_lat = -1;
    for (int i = 0; i < 40; i++) begin
      int r;
      logic [15:0] adr;
      r   = int'($urandom_range(0, 9));
      adr = addr_pool[$urandom_range(0, 5)];
      if (r < 4) begin
        issue_write(adr, 16'($urandom), 1'b0);
        wait_done("rand_write");
      end else if (r < 8) begin
        issue_read(adr, 1'b0);
        wait_done("rand_read");
      end else begin
        b = 8'($urandom_range(0, 255));
        while (b == 8'h01 || b == 8'h02) b = 8'($urandom_range(0, 255));
        send_byte(b);
        exp_drops++;
        repeat (4) @(negedge clk);
      end
    end
    check_counts("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
